eth_rx_addr_filter: RTL and testbench

//  Destination-address filter placed directly downstream of the 1G RGMII MAC RX AXI-stream (rx_clk domain, no backpressure).

---
 rtl/eth_rx_addr_filter.sv | 256 +++++++++++++++++++++++++
 tb/tb_eth_rx_addr_filter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_addr_filter.sv
// Destination-address filter on the MAC RX byte stream: holds the 6-byte DA, decides accept/drop
// per frame, forwards accepted frames 6 beats late and keeps per-frame statistics.
module eth_rx_addr_filter #(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter bit          RESET_PROMISC = 1'b0
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic [47:0]          cfg_local_mac,
  input  logic                 cfg_promisc,
  input  logic                 cfg_accept_bcast,
  input  logic                 cfg_accept_mcast,
  output logic [CNT_WIDTH-1:0] stat_frames_ok,
  output logic [CNT_WIDTH-1:0] stat_frames_filt,
  output logic [CNT_WIDTH-1:0] stat_frames_runt,
  output logic                 stat_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PASS  = 3'd2,
    ST_DROP  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [47:0]          BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  state_t               state_q, state_d;
  logic [7:0]           buf_data_q [6];
  logic [7:0]           buf_data_d [6];
  logic [5:0]           buf_last_q, buf_last_d;
  logic [5:0]           buf_user_q, buf_user_d;
  logic [2:0]           idx_q, idx_d;
  logic [47:0]          mac_q, mac_d;
  logic                 promisc_q, promisc_d;
  logic                 bcast_q, bcast_d;
  logic                 mcast_q, mcast_d;
  logic                 ovr_frame_q, ovr_frame_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic                 m_user_q, m_user_d;
  logic [CNT_WIDTH-1:0] ok_q, ok_d;
  logic [CNT_WIDTH-1:0] filt_q, filt_d;
  logic [CNT_WIDTH-1:0] runt_q, runt_d;
  logic                 overrun_q, overrun_d;
  logic [47:0]          da_s;
  logic                 accept_s;

  // DA is complete while byte 5 is on the input: bytes 0..4 sit in the buffer.
  assign da_s = {buf_data_q[0], buf_data_q[1], buf_data_q[2], buf_data_q[3], buf_data_q[4], s_axis_tdata};
  assign accept_s = promisc_q
                  | (da_s == mac_q)
                  | (bcast_q & (da_s == BCAST_ADDR))
                  | (mcast_q & da_s[40] & (da_s != BCAST_ADDR));

  // Next-state, buffer, output and statistics logic.
  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_user_d  = buf_user_q;
    idx_d       = idx_q;
    mac_d       = mac_q;
    promisc_d   = promisc_q;
    bcast_d     = bcast_q;
    mcast_d     = mcast_q;
    ovr_frame_d = ovr_frame_q;
    m_data_d    = 8'h00;
    m_valid_d   = 1'b0;
    m_last_d    = 1'b0;
    m_user_d    = 1'b0;
    ok_d        = ok_q;
    filt_d      = filt_q;
    runt_d      = runt_q;
    overrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          buf_data_d[0] = s_axis_tdata;
          buf_last_d    = 6'b00_0000;
          buf_user_d    = 6'b00_0000;
          mac_d         = cfg_local_mac;
          promisc_d     = cfg_promisc;
          bcast_d       = cfg_accept_bcast;
          mcast_d       = cfg_accept_mcast;
          idx_d         = 3'd1;
          if (s_axis_tlast) begin
            runt_d  = runt_q + CNT_ONE;
            idx_d   = 3'd0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HDR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (s_axis_tvalid) begin
          buf_data_d[idx_q] = s_axis_tdata;
          buf_last_d[idx_q] = s_axis_tlast;
          buf_user_d[idx_q] = s_axis_tlast & s_axis_tuser;
          if (idx_q == 3'd5) begin
            idx_d = 3'd0;
            if (accept_s) begin
              ovr_frame_d = 1'b0;
              state_d     = s_axis_tlast ? ST_FLUSH : ST_PASS;
            end else begin
              filt_d  = filt_q + CNT_ONE;
              state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
            end
          end else if (s_axis_tlast) begin
            runt_d     = runt_q + CNT_ONE;
            buf_last_d = 6'b00_0000;
            buf_user_d = 6'b00_0000;
            idx_d      = 3'd0;
            state_d    = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_HDR;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_PASS: begin
        if (s_axis_tvalid) begin
          m_valid_d = 1'b1;
          m_data_d  = buf_data_q[0];
          m_last_d  = buf_last_q[0];
          m_user_d  = buf_user_q[0];
          for (int i = 0; i < 5; i++) begin
            buf_data_d[i] = buf_data_q[i+1];
          end
          buf_data_d[5] = s_axis_tdata;
          buf_last_d    = {s_axis_tlast, buf_last_q[5:1]};
          buf_user_d    = {s_axis_tlast & s_axis_tuser, buf_user_q[5:1]};
          if (s_axis_tlast) begin
            idx_d       = 3'd0;
            ovr_frame_d = 1'b0;
            state_d     = ST_FLUSH;
          end else begin
            state_d = ST_PASS;
          end
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_FLUSH: begin
        m_valid_d = 1'b1;
        m_data_d  = buf_data_q[0];
        m_last_d  = buf_last_q[0];
        m_user_d  = buf_user_q[0];
        for (int i = 0; i < 5; i++) begin
          buf_data_d[i] = buf_data_q[i+1];
        end
        buf_data_d[5] = 8'h00;
        buf_last_d    = {1'b0, buf_last_q[5:1]};
        buf_user_d    = {1'b0, buf_user_q[5:1]};
        if (buf_last_q[0]) begin
          ok_d = ok_q + CNT_ONE;
        end else begin
          ok_d = ok_q;
        end
        // A beat arriving now is lost; remember whether its frame still has beats to discard.
        if (s_axis_tvalid) begin
          overrun_d   = 1'b1;
          ovr_frame_d = ~s_axis_tlast;
        end else begin
          ovr_frame_d = ovr_frame_q;
        end
        if (idx_q == 3'd5) begin
          idx_d   = 3'd0;
          state_d = ovr_frame_d ? ST_DROP : ST_IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_FLUSH;
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, buffer, configuration latch, output and counter registers.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q     <= ST_IDLE;
      buf_data_q  <= '{default: 8'h00};
      buf_last_q  <= 6'b00_0000;
      buf_user_q  <= 6'b00_0000;
      idx_q       <= 3'd0;
      mac_q       <= 48'h0000_0000_0000;
      promisc_q   <= RESET_PROMISC;
      bcast_q     <= 1'b0;
      mcast_q     <= 1'b0;
      ovr_frame_q <= 1'b0;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      ok_q        <= '0;
      filt_q      <= '0;
      runt_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_user_q  <= buf_user_d;
      idx_q       <= idx_d;
      mac_q       <= mac_d;
      promisc_q   <= promisc_d;
      bcast_q     <= bcast_d;
      mcast_q     <= mcast_d;
      ovr_frame_q <= ovr_frame_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      ok_q        <= ok_d;
      filt_q      <= filt_d;
      runt_q      <= runt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign m_axis_tdata     = m_data_q;
  assign m_axis_tvalid    = m_valid_q;
  assign m_axis_tlast     = m_last_q;
  assign m_axis_tuser     = m_user_q;
  assign stat_frames_ok   = ok_q;
  assign stat_frames_filt = filt_q;
  assign stat_frames_runt = runt_q;
  assign stat_overrun     = overrun_q;

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Randomized bench for eth_rx_addr_filter: a frame-level model predicts every output beat
// (with the edge it must appear on), overrun pulses and the statistics counters.
module tb_eth_rx_addr_filter;

  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic [47:0] local_mac = 48'h02_00_00_00_00_01;
  logic        promisc = 1'b0, bcast = 1'b0, mcast = 1'b0;
  logic [31:0] st_ok, st_filt, st_runt;
  logic        st_ovr;

  eth_rx_addr_filter #(.CNT_WIDTH(32), .RESET_PROMISC(1'b0)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .cfg_local_mac(local_mac), .cfg_promisc(promisc), .cfg_accept_bcast(bcast), .cfg_accept_mcast(mcast),
    .stat_frames_ok(st_ok), .stat_frames_filt(st_filt), .stat_frames_runt(st_runt), .stat_overrun(st_ovr)
  );

  always #4 rx_clk = ~rx_clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         edge_no;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  bit    ovr_exp[int];
  int    edge_cnt = 0;
  int    checks = 0, failures = 0;
  int    m_ok = 0, m_filt = 0, m_runt = 0;
  int    win_lo = 1, win_hi = 0;
  bit    out_chk_en = 1'b0;

  always @(posedge rx_clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic chk_counters();
    chk("stat_frames_ok", st_ok, m_ok);
    chk("stat_frames_filt", st_filt, m_filt);
    chk("stat_frames_runt", st_runt, m_runt);
  endtask

  function automatic bit model_accept(input logic [47:0] da);
    bit is_bcast;
    is_bcast = (da == 48'hFFFF_FFFF_FFFF);
    return promisc || (da == local_mac) || (bcast && is_bcast) || (mcast && da[40] && !is_bcast);
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic l, input logic u, input int e);
    beat_t b;
    b.data = d; b.last = l; b.user = u; b.edge_no = e;
    exp_q.push_back(b);
  endtask

  // Output monitor: every m_axis beat and every overrun pulse is compared against the model.
  always @(negedge rx_clk) begin
    if (!rx_rst && out_chk_en) begin
      chk("stat_overrun", st_ovr, ovr_exp.exists(edge_cnt));
      if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", m_tvalid, 1'b0);
        end else begin
          mon_b = exp_q[0];
          exp_q.delete(0);
          chk("m_tdata", m_tdata, mon_b.data);
          chk("m_tlast", m_tlast, mon_b.last);
          chk("m_tuser", m_tuser, mon_b.user);
          chk("m_edge", edge_cnt, mon_b.edge_no);
        end
      end else if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_cnt) begin
        chk("missing_valid", m_tvalid, 1'b1);
        exp_q.delete(0);
      end
    end
  end

  task automatic send_frame(input logic [47:0] da, input int len, input bit user, input int sparse);
    logic [7:0] bytes[$];
    logic [7:0] b;
    int e;
    bit ovr_frm, acc;
    ovr_frm = 1'b0;
    acc = (len >= 6) && model_accept(da);
    for (int n = 0; n < len; n++) begin
      if (sparse > 0) begin
        repeat ($urandom_range(sparse, 0)) begin
          s_tvalid = 1'b0;
          @(posedge rx_clk); #1;
        end
      end
      b = (n < 6) ? da[47-8*n -: 8] : 8'($urandom);
      s_tvalid = 1'b1;
      s_tdata  = b;
      s_tlast  = (n == len - 1);
      s_tuser  = (n == len - 1) ? user : 1'($urandom);
      @(posedge rx_clk); #1;
      e = edge_cnt;
      bytes.push_back(b);
      if (n == 0) ovr_frm = (e >= win_lo && e <= win_hi);
      if (ovr_frm) begin
        if (e >= win_lo && e <= win_hi) ovr_exp[e] = 1'b1;
      end else if (acc) begin
        if (n >= 6) push_exp(bytes[n-6], 1'b0, 1'b0, e);
        if (n == len - 1) begin
          for (int k = 0; k < 6; k++) push_exp(bytes[len-6+k], k == 5, (k == 5) && user, e + 1 + k);
          win_lo = e + 1;
          win_hi = e + 6;
        end
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    if (!ovr_frm) begin
      if (len < 6) m_runt++;
      else if (acc) m_ok++;
      else m_filt++;
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (n) begin @(posedge rx_clk); #1; end
    if (n >= 8) chk_counters();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_m_tvalid"}, m_tvalid, 1'b0);
    chk({tag, "_m_tdata"}, m_tdata, 8'h00);
    chk({tag, "_m_tlast"}, m_tlast, 1'b0);
    chk({tag, "_m_tuser"}, m_tuser, 1'b0);
    chk({tag, "_overrun"}, st_ovr, 1'b0);
    chk({tag, "_ok"}, st_ok, 32'd0);
    chk({tag, "_filt"}, st_filt, 32'd0);
    chk({tag, "_runt"}, st_runt, 32'd0);
  endtask

  function automatic logic [47:0] pick_da();
    logic [47:0] r;
    r = {16'($urandom), 32'($urandom)};
    case ($urandom_range(4, 0))
      0:       return local_mac;
      1:       return 48'hFFFF_FFFF_FFFF;
      2:       begin r[40] = 1'b1; return r; end
      3:       return local_mac ^ (48'h0000_0000_0001 << $urandom_range(47, 0));
      default: begin r[40] = 1'b0; return r; end
    endcase
  endfunction

  initial begin
    int len, r;
    repeat (3) @(posedge rx_clk);
    #1;
    check_reset_state("reset");
    rx_rst = 1'b0;
    out_chk_en = 1'b1;
    idle(4);

    // Station address, 64-byte frame, gap 12.
    send_frame(local_mac, 64, 1'b0, 0);
    idle(12);
    // Broadcast rejected, then accepted.
    send_frame(48'hFFFF_FFFF_FFFF, 64, 1'b0, 0);
    idle(12);
    bcast = 1'b1;
    send_frame(48'hFFFF_FFFF_FFFF, 64, 1'b0, 0);
    idle(12);
    bcast = 1'b0;
    // Runt, then a good frame right after.
    send_frame(local_mac, 4, 1'b0, 0);
    idle(1);
    send_frame(local_mac, 64, 1'b0, 0);
    idle(12);
    // Bad-FCS frame is still forwarded.
    send_frame(local_mac, 64, 1'b1, 0);
    idle(12);
    // Minimum-length boundaries: 5 bytes is a runt, 6 bytes accepted, 6 bytes rejected.
    send_frame(local_mac, 5, 1'b0, 0);
    idle(10);
    send_frame(local_mac, 6, 1'b1, 0);
    idle(10);
    send_frame(48'h02_00_00_00_00_02, 6, 1'b0, 0);
    idle(10);
    // Overrun: next frame starts 2 cycles after tlast.
    send_frame(local_mac, 64, 1'b0, 0);
    idle(1);
    send_frame(local_mac, 64, 1'b0, 0);
    idle(20);
    // Sparse (10/100-like) accepted frame.
    send_frame(local_mac, 40, 1'b0, 3);
    idle(12);

    // Reset at byte 20 of an accepted frame.
    out_chk_en = 1'b0;
    for (int n = 0; n < 20; n++) begin
      s_tvalid = 1'b1;
      s_tdata  = (n < 6) ? local_mac[47-8*n -: 8] : 8'(n);
      s_tlast  = 1'b0;
      @(posedge rx_clk); #1;
    end
    chk("pre_reset_ok_nonzero", st_ok != 32'd0, 1'b1);
    rx_rst = 1'b1;
    s_tvalid = 1'b0;
    @(posedge rx_clk); #1;
    check_reset_state("midframe_reset");
    exp_q.delete();
    ovr_exp.delete();
    m_ok = 0; m_filt = 0; m_runt = 0;
    win_lo = 1; win_hi = 0;
    @(posedge rx_clk); #1;
    rx_rst = 1'b0;
    out_chk_en = 1'b1;
    idle(2);
    send_frame(local_mac, 64, 1'b0, 0);
    idle(12);

    // Randomized frames, configurations, gaps and sparseness.
    for (int f = 0; f < 80; f++) begin
      promisc = ($urandom_range(7, 0) == 0);
      bcast   = 1'($urandom_range(1, 0));
      mcast   = 1'($urandom_range(1, 0));
      r = $urandom_range(9, 0);
      len = (r < 2) ? $urandom_range(5, 1) : ((r < 3) ? 6 : $urandom_range(80, 7));
      send_frame(pick_da(), len, 1'($urandom_range(1, 0)), $urandom_range(1, 0) * 2);
      idle($urandom_range(15, 0));
    end

    idle(20);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
